pipelined_addsub: RTL and testbench

//  Parametrised successor to the 12-bit ripple adder.

---
 rtl/pipelined_addsub.sv | 122 ++++++++++++
 tb/tb_pipelined_addsub.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined ADD/SUB/ADC/SBB unit: the carry chain is cut into STAGE_W-bit slices,
// one register stage per slice, with valid/ready flow control on both sides.
module pipelined_addsub #(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned STAGE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int unsigned NSTAGES = (WIDTH + STAGE_W - 1) / STAGE_W;

    logic [NSTAGES-1:0] v_all_c;

    assign in_ready = g_st[0].en_c;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_st
        localparam int unsigned LO = k * STAGE_W;
        localparam int unsigned HI = (LO + STAGE_W < WIDTH) ? LO + STAGE_W : WIDTH;
        localparam int unsigned SW = HI - LO;
        localparam int unsigned RW = WIDTH - LO;

        logic          v_q;
        logic          cy_q;
        logic [HI-1:0] s_q;
        logic          en_c;
        logic          load_c;
        logic          v_in_c;
        logic          c_in_c;
        logic [RW-1:0] a_rem_c;
        logic [RW-1:0] b_rem_c;
        logic [HI-1:0] s_next_c;
        logic [SW:0]   slice_c;

        // A stage may load while any stage from here to the output is empty or the sink drains.
        assign v_all_c[k] = v_q;
        assign en_c       = out_ready | ~(&v_all_c[NSTAGES-1:k]);
        assign load_c     = en_c & v_in_c;
        assign slice_c    = {1'b0, a_rem_c[SW-1:0]} + {1'b0, b_rem_c[SW-1:0]} + (SW+1)'(c_in_c);

        if (k == 0) begin : g_head
            // Subtraction is A + ~B with carry-in 1 (SUB) or Cin (SBB).
            assign v_in_c   = in_valid;
            assign a_rem_c  = A;
            assign b_rem_c  = mode[0] ? ~B : B;
            assign c_in_c   = mode[1] ? Cin : mode[0];
            assign s_next_c = slice_c[SW-1:0];
        end else begin : g_body
            assign v_in_c   = g_st[k-1].v_q;
            assign a_rem_c  = g_st[k-1].g_fwd.a_q;
            assign b_rem_c  = g_st[k-1].g_fwd.b_q;
            assign c_in_c   = g_st[k-1].cy_q;
            assign s_next_c = {slice_c[SW-1:0], g_st[k-1].s_q};
        end

        // Data only moves with a valid beat so idle X operands never reach the outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q  <= 1'b0;
                cy_q <= 1'b0;
                s_q  <= '0;
            end else begin
                if (en_c) begin
                    v_q <= v_in_c;
                end
                if (load_c) begin
                    cy_q <= slice_c[SW];
                    s_q  <= s_next_c;
                end
            end
        end

        if (k < NSTAGES - 1) begin : g_fwd
            // Skew registers: operand bits not yet consumed travel with the beat.
            logic [WIDTH-HI-1:0] a_q;
            logic [WIDTH-HI-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load_c) begin
                    a_q <= a_rem_c[RW-1:SW];
                    b_q <= b_rem_c[RW-1:SW];
                end
            end
        end else begin : g_tail
            logic ovf_q;
            logic zero_q;

            // Carry into the true MSB is recovered as sum ^ a ^ b at that bit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (load_c) begin
                    ovf_q  <= slice_c[SW] ^ (slice_c[SW-1] ^ a_rem_c[SW-1] ^ b_rem_c[SW-1]);
                    zero_q <= ~|s_next_c;
                end
            end

            assign out_valid = v_q;
            assign S         = s_q;
            assign Cout      = cy_q;
            assign Ovf       = ovf_q;
            assign Zero      = zero_q;
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: four instances (STAGE_W 4,1,5,12) checked against an
// integer-arithmetic reference model through per-instance in-order scoreboards.
module tb_pipelined_addsub;

    localparam int unsigned W  = 12;
    localparam int unsigned ND = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic [1:0]    mode;
    logic [ND-1:0] iv;
    logic [ND-1:0] ordy;
    logic [ND-1:0] ir;
    logic [ND-1:0] ov;
    logic [ND-1:0] co;
    logic [ND-1:0] of;
    logic [ND-1:0] zf;
    logic [W-1:0]  s [ND];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [14:0] sbq [ND][$];
    bit          hold_prev [ND];
    logic [14:0] held [ND];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        case (d)
            0:       return 3;
            1:       return 12;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    // Reference: {Cout, Ovf, Zero, S} from plain signed/unsigned integer arithmetic.
    function automatic logic [14:0] ref_op(input logic [1:0] m, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic c);
        int ux, uy, sx, sy, ci, ur, sr;
        logic cout, ovf;
        logic [W-1:0] r;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 2048) ? ux - 4096 : ux;
        sy = (uy >= 2048) ? uy - 4096 : uy;
        ci = (m == 2'b00) ? 0 : (m == 2'b01) ? 1 : int'(c);
        if (!m[0]) begin
            ur   = ux + uy + ci;
            sr   = sx + sy + ci;
            cout = (ur > 4095);
        end else begin
            ur   = ux - uy - (1 - ci);
            sr   = sx - sy - (1 - ci);
            cout = (ur >= 0);
        end
        ovf = (sr > 2047) || (sr < -2048);
        r   = W'(ur);
        return {cout, ovf, (r == '0), r};
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int unsigned SWG = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 5 : 12;

        pipelined_addsub #(.WIDTH(W), .STAGE_W(SWG)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (iv[g]),
            .in_ready (ir[g]),
            .A        (a),
            .B        (b),
            .Cin      (cin),
            .mode     (mode),
            .out_valid(ov[g]),
            .out_ready(ordy[g]),
            .S        (s[g]),
            .Cout     (co[g]),
            .Ovf      (of[g]),
            .Zero     (zf[g])
        );

        // Monitor: handshakes settle before the falling edge and fire on the next rising edge.
        initial begin
            forever begin
                @(negedge clk);
                if (rst) begin
                    sbq[g].delete();
                    hold_prev[g] = 1'b0;
                end else begin
                    chk($sformatf("d%0d in_ready", g), 32'(ir[g]),
                        32'((sbq[g].size() < lat_of(g)) || ordy[g]));
                    if (hold_prev[g]) begin
                        chk($sformatf("d%0d stall valid", g), 32'(ov[g]), 32'(1));
                        chk($sformatf("d%0d stall hold", g),
                            32'({co[g], of[g], zf[g], s[g]}), 32'(held[g]));
                    end
                    if (sbq[g].size() == 0) begin
                        chk($sformatf("d%0d idle valid", g), 32'(ov[g]), 32'(0));
                    end else if (ov[g] && ordy[g]) begin
                        chk($sformatf("d%0d result", g),
                            32'({co[g], of[g], zf[g], s[g]}), 32'(sbq[g][0]));
                        sbq[g].delete(0);
                    end
                    hold_prev[g] = ov[g] & ~ordy[g];
                    held[g]      = {co[g], of[g], zf[g], s[g]};
                    if (iv[g] && ir[g]) begin
                        sbq[g].push_back(ref_op(mode, a, b, cin));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ops();
        a    = 'x;
        b    = 'x;
        mode = 'x;
        cin  = 'x;
    endtask

    task automatic rand_ops();
        mode = 2'($urandom);
        a    = W'($urandom);
        b    = W'($urandom);
        cin  = 1'($urandom);
    endtask

    // One beat into instance d with out_ready high; checks acceptance, latency and result.
    task automatic one_beat(input int d, input string tag, input logic [1:0] m,
                            input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                            input logic [14:0] exp);
        int n;
        mode  = m;
        a     = x;
        b     = y;
        cin   = c;
        iv[d] = 1'b1;
        #1;
        chk({tag, " ready"}, 32'(ir[d]), 32'(1));
        tick();
        iv[d] = 1'b0;
        idle_ops();
        n = 1;
        while (!ov[d] && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat_of(d)));
        chk({tag, " result"}, 32'({co[d], of[d], zf[d], s[d]}), 32'(exp));
    endtask

    task automatic stall_stream();
        ordy = '1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    int  guard;
                    logic took;
                    guard = 0;
                    took  = 1'b0;
                    rand_ops();
                    iv[0] = 1'b1;
                    while (!took && guard < 50) begin
                        @(negedge clk);
                        took = ir[0];
                        tick();
                        guard++;
                    end
                    chk($sformatf("stream beat %0d accepted", i), 32'(took), 32'(1));
                end
                iv[0] = 1'b0;
                idle_ops();
            end
            begin
                repeat (4) tick();
                ordy[0] = 1'b0;
                repeat (4) tick();
                @(negedge clk);
                chk("stall full in_ready", 32'(ir[0]), 32'(0));
                chk("stall out_valid", 32'(ov[0]), 32'(1));
                tick();
                ordy[0] = 1'b1;
            end
        join
        repeat (20) tick();
        chk("stream drained", 32'(sbq[0].size()), 32'(0));
    endtask

    task automatic reset_mid();
        ordy[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_ops();
            iv[0] = 1'b1;
            tick();
        end
        iv[0] = 1'b0;
        idle_ops();
        tick();
        chk("pre-rst out_valid", 32'(ov[0]), 32'(1));
        rst = 1'b1;
        #1;
        chk("rst out_valid", 32'(ov[0]), 32'(0));
        chk("rst flags/S", 32'({co[0], of[0], zf[0], s[0]}), 32'(0));
        tick();
        rst     = 1'b0;
        ordy[0] = 1'b1;
        repeat (6) begin
            chk("post-rst out_valid", 32'(ov[0]), 32'(0));
            chk("post-rst in_ready", 32'(ir[0]), 32'(1));
            tick();
        end
        one_beat(0, "post-rst beat", 2'b00, 12'h123, 12'h456, 1'b0, ref_op(2'b00, 12'h123, 12'h456, 1'b0));
    endtask

    task automatic sweep_stream();
        for (int i = 0; i < 60; i++) begin
            ordy = ND'($urandom) | ND'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                rand_ops();
                iv = '1;
            end else begin
                iv = '0;
                idle_ops();
            end
            tick();
        end
        iv   = '0;
        ordy = '1;
        idle_ops();
        repeat (20) tick();
        for (int d = 0; d < int'(ND); d++) begin
            chk($sformatf("d%0d sweep drained", d), 32'(sbq[d].size()), 32'(0));
        end
    endtask

    initial begin
        logic [1:0]   m;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        rst  = 1'b1;
        iv   = '0;
        ordy = '1;
        idle_ops();
        repeat (3) tick();
        rst = 1'b0;
        #1;
        for (int d = 0; d < int'(ND); d++) begin
            chk($sformatf("d%0d reset outputs", d), 32'({ov[d], co[d], of[d], zf[d], s[d]}), 32'(0));
            chk($sformatf("d%0d reset in_ready", d), 32'(ir[d]), 32'(1));
        end
        tick();

        one_beat(0, "ADD FFF+001", 2'b00, 12'hFFF, 12'h001, 1'b1, {1'b1, 1'b0, 1'b1, 12'h000});
        one_beat(0, "SUB 800-001", 2'b01, 12'h800, 12'h001, 1'b0, {1'b1, 1'b1, 1'b0, 12'h7FF});
        one_beat(0, "SUB 005-005", 2'b01, 12'h005, 12'h005, 1'b1, {1'b1, 1'b0, 1'b1, 12'h000});
        one_beat(0, "ADC 7FF+000", 2'b10, 12'h7FF, 12'h000, 1'b1, {1'b0, 1'b1, 1'b0, 12'h800});
        one_beat(0, "SBB 000,001", 2'b11, 12'h000, 12'h001, 1'b1, {1'b0, 1'b0, 1'b0, 12'hFFF});

        for (int d = 0; d < int'(ND); d++) begin
            m = 2'($urandom);
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            one_beat(d, $sformatf("d%0d sweep beat", d), m, x, y, c, ref_op(m, x, y, c));
        end

        stall_stream();
        reset_mid();
        sweep_stream();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, %0d checks so far", n_tests);
        $fatal(1);
    end

endmodule
